i2s_rx: RTL

//   I2S slave receiver, counterpart to our I2S DAC transmit path: takes BCK, LRCK and DIN

---
 rtl/i2s_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// i2s_rx -- I2S slave receiver.
//
// Oversamples an externally mastered I2S bus (BCK, LRCK, DIN) on the system
// clock and delivers complete left/right sample pairs on a valid/ready
// handshake. Slots wider than SAMPLE_BITS are truncated (MSBs kept). Slots
// narrower than SAMPLE_BITS are left-justified and zero-padded.
//
// Ports:
//   clk        system clock, at least 4x the BCK frequency
//   sys_rst_i  synchronous active-high reset
//   bck_i      I2S bit clock (asynchronous)
//   lrck_i     I2S word select, 0 = left, 1 = right (asynchronous)
//   din_i      I2S serial data, MSB first (asynchronous)
//   left_o     left word of the delivered pair
//   right_o    right word of the delivered pair
//   valid_o    left_o/right_o hold a pair not yet accepted
//   ready_i    consumer accepts the pair when valid_o && ready_i
//   overrun_o  one-cycle pulse: a completed pair was dropped
//   locked_o   high once the first LRCK transition has been seen
module i2s_rx #(
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   sys_rst_i,
  input  logic                   bck_i,
  input  logic                   lrck_i,
  input  logic                   din_i,
  output logic [SAMPLE_BITS-1:0] left_o,
  output logic [SAMPLE_BITS-1:0] right_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overrun_o,
  output logic                   locked_o
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_BITS);

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  state_t state;
  state_t state_next;

  // All three inputs share one synchroniser depth so that lr and d stay
  // aligned with the detected BCK rise.
  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] din_sync;

  logic bck_s;
  logic lr;
  logic d;
  logic bck_prev;
  logic rise;
  logic lr_d;
  logic edge_seen;

  logic [SAMPLE_BITS-1:0] word;
  logic [SAMPLE_BITS-1:0] word_next;
  logic [CNT_W-1:0]       cnt;
  logic [SAMPLE_BITS-1:0] left_hold;
  logic                   have_left;

  logic store_left;
  logic pair_done;
  logic clr_left;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sys_rst_i) begin
      bck_sync <= '0;
      lr_sync  <= '0;
      din_sync <= '0;
      bck_prev <= 1'b0;
    end else begin
      bck_sync <= {bck_sync[SYNC_STAGES-2:0], bck_i};
      lr_sync  <= {lr_sync[SYNC_STAGES-2:0], lrck_i};
      din_sync <= {din_sync[SYNC_STAGES-2:0], din_i};
      bck_prev <= bck_s;
    end
  end

  assign bck_s     = bck_sync[SYNC_STAGES-1];
  assign lr        = lr_sync[SYNC_STAGES-1];
  assign d         = din_sync[SYNC_STAGES-1];
  assign rise      = bck_s & ~bck_prev;
  assign edge_seen = rise & (lr != lr_d);

  // ---------------------------------------------------------------------
  // Bit capture
  // ---------------------------------------------------------------------
  // Every bit position is written at most once between clears, so OR-ing
  // a shifted one-hot is equivalent to a per-bit write and avoids a
  // variable part-select.
  always_comb begin
    word_next = word;
    if (cnt < CNT_MAX) begin
      word_next = word | ({d, {(SAMPLE_BITS-1){1'b0}}} >> cnt);
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sys_rst_i) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    store_left = 1'b0;
    pair_done  = 1'b0;
    clr_left   = 1'b0;
    locked_o   = 1'b0;
    case (state)
      HUNT: begin
        // The word completed at the first edge is never trustworthy.
        if (edge_seen) begin
          state_next = RUN;
          clr_left   = 1'b1;
        end
      end
      RUN: begin
        locked_o = 1'b1;
        if (edge_seen) begin
          if (!lr_d) begin
            store_left = 1'b1;
          end else if (have_left) begin
            pair_done = 1'b1;
            clr_left  = 1'b1;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and output handshake
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sys_rst_i) begin
      lr_d      <= 1'b0;
      word      <= '0;
      cnt       <= '0;
      left_hold <= '0;
      have_left <= 1'b0;
      left_o    <= '0;
      right_o   <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;

      if (rise) begin
        lr_d <= lr;
        // On a transition edge the current bit is the LSB of the slot just
        // ending (one-BCK I2S delay); it is folded into word_next before
        // the capture restarts for the next slot's MSB.
        if (edge_seen) begin
          word <= '0;
          cnt  <= '0;
        end else begin
          word <= word_next;
          if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end

      if (store_left) begin
        left_hold <= word_next;
        have_left <= 1'b1;
      end else if (clr_left) begin
        have_left <= 1'b0;
      end

      if (pair_done && (!valid_o || ready_i)) begin
        left_o  <= left_hold;
        right_o <= word_next;
        valid_o <= 1'b1;
      end else if (pair_done) begin
        overrun_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
